// File: rtl/btn_mode_ctrl.sv
// Push-button front end: sync, debounce, press/long-press events and the display-mode register.
// Optional macro BTN_AUTOREPEAT_EN: re-fires press every REPEAT_CYCLES while a button is held past long press.
module btn_mode_lane #(
  parameter int DEBOUNCE_CYCLES   = 50_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_held,
  output logic o_rise,
  output logic o_rep,
  output logic o_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_LONG} state_t;

  logic          r_s1, r_s2, r_held, r_rise, r_long;
  logic [DW-1:0] r_cnt;
  logic [HW-1:0] r_hcnt;
  state_t        r_state;
  logic          w_flip, w_held_nxt;

  // FSM decisions look at the level held will have after this edge, so a
  // release never coincides with a long-press or repeat pulse.
  assign w_flip     = (r_s2 != r_held) && (r_cnt == DMAX);
  assign w_held_nxt = r_held ^ w_flip;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rcnt;
  logic          r_rep;
  assign o_rep = r_rep;
`else
  assign o_rep = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_held  <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_long  <= 1'b0;
      r_hcnt  <= '0;
      r_state <= ST_IDLE;
`ifdef BTN_AUTOREPEAT_EN
      r_rcnt  <= '0;
      r_rep   <= 1'b0;
`endif
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_held <= w_held_nxt;
      r_cnt  <= (r_s2 == r_held || w_flip) ? '0 : r_cnt + 1'b1;
      r_rise <= w_flip & ~r_held;
      r_long <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rep  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_flip && !r_held) begin
            r_state <= ST_PRESS;
            r_hcnt  <= '0;
          end
        end
        ST_PRESS: begin
          if (!w_held_nxt) begin
            r_state <= ST_IDLE;
          end else if (r_hcnt == HMAX) begin
            r_state <= ST_LONG;
            r_long  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            r_rcnt  <= '0;
`endif
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        ST_LONG: begin
`ifdef BTN_AUTOREPEAT_EN
          if (!w_held_nxt) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
          end else if (r_rcnt == RMAX) begin
            r_rcnt <= '0;
            r_rep  <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
`else
          if (!w_held_nxt) r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_held = r_held;
  assign o_rise = r_rise;
  assign o_long = r_long;
endmodule

module btn_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 50_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 10_000_000,
  parameter int NUM_MODES         = 3,
  parameter int MODE_BTN          = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_btn,
  output logic [7:0] o_held,
  output logic [7:0] o_press,
  output logic [7:0] o_long_press,
  output logic [3:0] o_mode,
  output logic       o_mode_changed
);
  logic [7:0] w_rise, w_rep;
  logic [3:0] r_mode;
  logic       r_mode_changed;

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1 ||
      NUM_MODES < 1 || NUM_MODES > 16 || MODE_BTN < 0 || MODE_BTN > 7) begin : g_bad_param
    $error("btn_mode_ctrl: illegal parameter value");
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    btn_mode_lane #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_btn (i_btn[g]),
      .o_held(o_held[g]),
      .o_rise(w_rise[g]),
      .o_rep (w_rep[g]),
      .o_long(o_long_press[g])
    );
  end

  assign o_press = w_rise | w_rep;

  // Only the debounced edge advances the mode; auto-repeat pulses never do.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode         <= '0;
      r_mode_changed <= 1'b0;
    end else begin
      r_mode_changed <= w_rise[MODE_BTN];
      if (w_rise[MODE_BTN])
        r_mode <= (r_mode == 4'(NUM_MODES - 1)) ? 4'd0 : r_mode + 4'd1;
    end
  end

  assign o_mode         = r_mode;
  assign o_mode_changed = r_mode_changed;
endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: history-window reference model checked every cycle plus directed literal checks.
module tb_btn_mode_ctrl;
  localparam int D = 4, L = 20, R = 5, NM = 3, MB = 0;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn, held, press, lp;
  logic [3:0] mode;
  logic       mchg;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  btn_mode_ctrl #(
    .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R),
    .NUM_MODES(NM), .MODE_BTN(MB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_held(held), .o_press(press), .o_long_press(lp),
    .o_mode(mode), .o_mode_changed(mchg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reference model: held flips once the last D synchronised samples all
  // disagree with it; events follow from the time elapsed since the rise.
  bit          mvalid = 1'b0;
  int unsigned now;
  logic [7:0]  p1, p2, m_held, m_press, m_long, m_rise;
  logic [31:0] hs [8];
  int unsigned t_rise [8];
  logic        prev_r0, m_mchg, fl;
  logic [3:0]  m_mode;

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1'b1;
      now = 0; p1 = '0; p2 = '0; m_held = '0; m_press = '0; m_long = '0; m_rise = '0;
      prev_r0 = 1'b0; m_mchg = 1'b0; m_mode = '0;
      for (int i = 0; i < 8; i++) begin hs[i] = '0; t_rise[i] = 0; end
    end else begin
      now++;
      m_mchg = prev_r0;
      if (prev_r0) m_mode = 4'((int'(m_mode) + 1) % NM);
      for (int i = 0; i < 8; i++) begin
        hs[i] = {hs[i][30:0], p2[i]};
        fl = (((hs[i] ^ {32{m_held[i]}}) & MASK) == MASK);
        m_rise[i] = fl && !m_held[i];
        m_held[i] = m_held[i] ^ fl;
        if (m_rise[i]) t_rise[i] = now;
        m_press[i] = m_rise[i];
        m_long[i]  = m_held[i] && (now - t_rise[i] == L);
        if (REP && m_held[i] && !m_rise[i] && (now - t_rise[i] > L) &&
            ((now - t_rise[i] - L) % R == 0))
          m_press[i] = 1'b1;
      end
      prev_r0 = m_rise[MB];
      p2 = p1;
      p1 = btn;
    end
  end

  int n_p5 = 0, n_lp5 = 0, saw_p2 = 0;
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_held",  held,  m_held);
      chk("model_press", press, m_press);
      chk("model_long",  lp,    m_long);
      chk("model_mode",  mode,  m_mode);
      chk("model_mchg",  mchg,  m_mchg);
    end
    n_p5   += int'(press[5]);
    n_lp5  += int'(lp[5]);
    saw_p2 += int'(press[2]);
  end

  logic [4:0] bounce;
  logic [3:0] exp_modes [4];

  initial begin
    rst = 1'b1;
    btn = '0;
    tick(1);
    chk("rst_held", held, 0);
    chk("rst_press", press, 0);
    chk("rst_long", lp, 0);
    chk("rst_mode", mode, 0);
    chk("rst_mchg", mchg, 0);
    rst = 1'b0;

    // clean step on button 3
    btn[3] = 1'b1;
    tick(5);
    chk("step_held_c5", held[3], 0);
    tick(1);
    chk("step_held_c6", held[3], 1);
    chk("step_press_c6", press, 8'h08);
    tick(1);
    chk("step_press_c7", press[3], 0);
    btn[3] = 1'b0;
    tick(10);

    // bounce on button 2
    bounce = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      btn[2] = bounce[k];
      tick(1);
    end
    btn[2] = 1'b0;
    tick(10);
    chk("bounce_held", held[2], 0);
    chk("bounce_press_seen", saw_p2, 0);

    // four presses of the mode button
    exp_modes[0] = 4'd1; exp_modes[1] = 4'd2; exp_modes[2] = 4'd0; exp_modes[3] = 4'd1;
    for (int k = 0; k < 4; k++) begin
      btn[0] = 1'b1;
      tick(6);
      chk("mode_press", press[0], 1);
      tick(1);
      chk("mode_value", mode, exp_modes[k]);
      chk("mode_chg_pulse", mchg, 1);
      tick(1);
      chk("mode_chg_end", mchg, 0);
      tick(2);
      btn[0] = 1'b0;
      tick(10);
    end

    // long hold on button 5
    btn[5] = 1'b1;
    tick(6);
    chk("long_press_c6", press[5], 1);
    tick(19);
    chk("long_c25", lp[5], 0);
    tick(1);
    chk("long_c26", lp, 8'h20);
    tick(1);
    chk("long_c27", lp[5], 0);
    tick(4);
    chk("repeat_c31", press[5], REP);
    tick(9);
    btn[5] = 1'b0;
    tick(12);
    chk("long_count", n_lp5, 1);
    chk("press5_count", n_p5, REP ? 4 : 1);
    chk("long_mode_kept", mode, 1);

    // simultaneous presses
    btn[7:6] = 2'b11;
    tick(6);
    chk("simul_press", press, 8'hC0);
    btn[7:6] = 2'b00;
    tick(10);

    // mode button held past long press: only the first edge counts
    btn[0] = 1'b1;
    tick(35);
    btn[0] = 1'b0;
    tick(10);
    chk("hold_mode", mode, 2);

    // reset while the mode button is held
    btn[0] = 1'b1;
    tick(10);
    chk("pre_rst_mode", mode, 0);
    rst = 1'b1;
    tick(1);
    chk("midrst_mode", mode, 0);
    chk("midrst_held", held[0], 0);
    rst = 1'b0;
    tick(5);
    chk("rehold_c5", press[0], 0);
    tick(1);
    chk("rehold_c6", press[0], 1);
    chk("rehold_held", held[0], 1);
    tick(1);
    chk("rehold_mode", mode, 1);
    chk("rehold_mchg", mchg, 1);
    btn[0] = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
